// File: rtl/arbitro_hamming.sv
// Round-robin arbiter for two requesters sharing one Hamming(15,11) SEC datapath,
// with a registered valid/ready output stage and saturating per-requester error counters.
module arbitro_hamming #(
  parameter int LARGURA_CONT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [14:0]             req0_dado,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [14:0]             req1_dado,
  output logic                    req1_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [10:0]             out_dado,
  output logic [3:0]              out_sindrome,
  output logic                    out_erro,
  output logic                    out_id,
  input  logic                    limpa_cont,
  output logic [LARGURA_CONT-1:0] cont_corr0,
  output logic [LARGURA_CONT-1:0] cont_corr1
);

  localparam logic [LARGURA_CONT-1:0] CONT_MAX = '1;

  logic                    prio_q, prio_d;
  logic                    out_valid_q, out_valid_d;
  logic [10:0]             out_dado_q, out_dado_d;
  logic [3:0]              out_sindrome_q, out_sindrome_d;
  logic                    out_erro_q, out_erro_d;
  logic                    out_id_q, out_id_d;
  logic [LARGURA_CONT-1:0] cont0_q, cont0_d;
  logic [LARGURA_CONT-1:0] cont1_q, cont1_d;

  logic        pode, grant0, grant1, aceita, id_sel;
  logic [14:0] palavra, corrigida;
  logic [3:0]  sindrome, pos_erro;
  logic [10:0] dado_corr;

  // When both request, prio picks; a lone requester always wins.
  always_comb begin
    pode    = !out_valid_q || out_ready;
    grant0  = req0_valid && (!req1_valid || !prio_q);
    grant1  = req1_valid && (!req0_valid || prio_q);
    id_sel  = grant1;
    palavra = grant1 ? req1_dado : req0_dado;
    aceita  = pode && (grant0 || grant1);
  end

  assign req0_ready = pode && grant0;
  assign req1_ready = pode && grant1;

  always_comb begin
    sindrome[0] = ^(palavra & 15'h5555);
    sindrome[1] = ^(palavra & 15'h6666);
    sindrome[2] = ^(palavra & 15'h7878);
    sindrome[3] = ^(palavra & 15'h7F80);
    pos_erro    = sindrome - 4'd1;
    corrigida   = palavra;
    if (sindrome != 4'd0) begin
      corrigida[pos_erro] = ~palavra[pos_erro];
    end
    dado_corr = {corrigida[14:8], corrigida[6:4], corrigida[2]};
  end

  // Counter clear is applied last so it overrides a same-cycle increment.
  always_comb begin
    prio_d         = prio_q;
    out_valid_d    = out_valid_q;
    out_dado_d     = out_dado_q;
    out_sindrome_d = out_sindrome_q;
    out_erro_d     = out_erro_q;
    out_id_d       = out_id_q;
    cont0_d        = cont0_q;
    cont1_d        = cont1_q;
    if (aceita) begin
      out_valid_d    = 1'b1;
      out_dado_d     = dado_corr;
      out_sindrome_d = sindrome;
      out_erro_d     = (sindrome != 4'd0);
      out_id_d       = id_sel;
      prio_d         = !id_sel;
      if (sindrome != 4'd0) begin
        if (!id_sel && cont0_q != CONT_MAX) begin
          cont0_d = cont0_q + LARGURA_CONT'(1);
        end
        if (id_sel && cont1_q != CONT_MAX) begin
          cont1_d = cont1_q + LARGURA_CONT'(1);
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (limpa_cont) begin
      cont0_d = '0;
      cont1_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_dado_q     <= '0;
      out_sindrome_q <= '0;
      out_erro_q     <= 1'b0;
      out_id_q       <= 1'b0;
      cont0_q        <= '0;
      cont1_q        <= '0;
    end else begin
      prio_q         <= prio_d;
      out_valid_q    <= out_valid_d;
      out_dado_q     <= out_dado_d;
      out_sindrome_q <= out_sindrome_d;
      out_erro_q     <= out_erro_d;
      out_id_q       <= out_id_d;
      cont0_q        <= cont0_d;
      cont1_q        <= cont1_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_dado     = out_dado_q;
  assign out_sindrome = out_sindrome_q;
  assign out_erro     = out_erro_q;
  assign out_id       = out_id_q;
  assign cont_corr0   = cont0_q;
  assign cont_corr1   = cont1_q;

endmodule

// File: tb/tb_arbitro_hamming.sv
// Self-checking bench for arbitro_hamming: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_arbitro_hamming;

  localparam int W    = 8;
  localparam int CMAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [14:0]   req0_dado, req1_dado;
  logic          out_valid, out_ready, out_erro, out_id, limpa_cont;
  logic [10:0]   out_dado;
  logic [3:0]    out_sindrome;
  logic [W-1:0]  cont_corr0, cont_corr1;

  always #5 clk = ~clk;

  arbitro_hamming #(.LARGURA_CONT(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_dado(req0_dado), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dado(req1_dado), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_dado(out_dado),
    .out_sindrome(out_sindrome), .out_erro(out_erro), .out_id(out_id),
    .limpa_cont(limpa_cont), .cont_corr0(cont_corr0), .cont_corr1(cont_corr1)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state
  bit          modelValid = 1'b0;
  bit          mValid, mErro, mId, mPrio;
  logic [10:0] mDado;
  logic [3:0]  mSind;
  int          mC0, mC1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Syndrome of a Hamming word is the XOR of the positions of its set bits
  function automatic logic [3:0] refSyndrome(input logic [14:0] w);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < 15; i++) if (w[i]) s ^= 4'(i + 1);
    return s;
  endfunction

  // Data bits sit at non-power-of-two positions, lowest position first
  function automatic logic [10:0] refData(input logic [14:0] w);
    logic [14:0] c = w;
    logic [10:0] d = '0;
    int s = int'(refSyndrome(w));
    int k = 0;
    if (s != 0) c[s-1] = ~c[s-1];
    for (int pos = 1; pos <= 15; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic stepCycle();
    bit pode, anyValid, winner, acc;
    logic [14:0] w;
    logic [3:0] s;
    @(negedge clk);
    pode     = !mValid || out_ready;
    anyValid = req0_valid || req1_valid;
    winner   = (req0_valid && req1_valid) ? mPrio : req1_valid;
    acc      = pode && anyValid;
    if (modelValid) begin
      checkOutput("req0_ready", req0_ready, acc && !winner);
      checkOutput("req1_ready", req1_ready, acc && winner);
      checkOutput("out_valid", out_valid, mValid);
      checkOutput("out_dado", out_dado, mDado);
      checkOutput("out_sindrome", out_sindrome, mSind);
      checkOutput("out_erro", out_erro, mErro);
      checkOutput("out_id", out_id, mId);
      checkOutput("cont_corr0", cont_corr0, mC0);
      checkOutput("cont_corr1", cont_corr1, mC1);
    end
    @(posedge clk);
    if (rst) begin
      modelValid = 1'b1;
      mValid = 0; mErro = 0; mId = 0; mPrio = 0;
      mDado = '0; mSind = '0; mC0 = 0; mC1 = 0;
    end else if (modelValid) begin
      if (acc) begin
        w = winner ? req1_dado : req0_dado;
        s = refSyndrome(w);
        mDado = refData(w); mSind = s; mErro = (s != 0);
        mId = winner; mValid = 1; mPrio = !winner;
        if (s != 0) begin
          if (winner) mC1 = (mC1 < CMAX) ? mC1 + 1 : mC1;
          else        mC0 = (mC0 < CMAX) ? mC0 + 1 : mC0;
        end
      end else if (out_ready) begin
        mValid = 0;
      end
      if (limpa_cont) begin
        mC0 = 0; mC1 = 0;
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit v0, input logic [14:0] d0,
                               input bit v1, input logic [14:0] d1,
                               input bit ordy, input bit lim);
    rst = r; req0_valid = v0; req0_dado = d0; req1_valid = v1; req1_dado = d1;
    out_ready = ordy; limpa_cont = lim;
    stepCycle();
  endtask

  function automatic logic [14:0] randomWord();
    logic [14:0] w = 15'($urandom);
    logic [3:0] s = refSyndrome(w);
    if (s != 0) w[s-1] = ~w[s-1];
    if ($urandom_range(0, 1) == 1) begin
      int b = $urandom_range(0, 14);
      w[b] = ~w[b];
    end
    return w;
  endfunction

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_cont0", cont_corr0, 0);

    // Clean words from requester 0
    applyStimulus(0, 1, 15'h0000, 0, 0, 1, 0);
    checkOutput("clean0_dado", out_dado, 11'h000);
    applyStimulus(0, 1, 15'h7FFF, 0, 0, 1, 0);
    checkOutput("clean1_dado", out_dado, 11'h7FF);
    checkOutput("clean1_erro", out_erro, 0);

    // Single-bit data errors from requester 1
    applyStimulus(0, 0, 0, 1, 15'h3FFF, 1, 0);
    checkOutput("err14_dado", out_dado, 11'h7FF);
    checkOutput("err14_sind", out_sindrome, 4'hF);
    applyStimulus(0, 0, 0, 1, 15'h0004, 1, 0);
    checkOutput("err2_dado", out_dado, 11'h000);
    checkOutput("err2_sind", out_sindrome, 4'h3);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("cont1_two", cont_corr1, 2);

    // Parity-position error leaves data untouched
    applyStimulus(0, 1, 15'h0080, 0, 0, 1, 0);
    checkOutput("par_sind", out_sindrome, 4'h8);
    checkOutput("par_dado", out_dado, 11'h000);
    checkOutput("par_erro", out_erro, 1);

    // Round-robin from reset with both requesting
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, randomWord(), 1, randomWord(), 1, 0);
      checkOutput("rr_id", out_id, i % 2);
    end

    // Backpressure then release
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, randomWord(), 1, randomWord(), 0, 0);
    applyStimulus(0, 1, randomWord(), 1, randomWord(), 1, 0);

    // Saturation and clear of counter 0
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) applyStimulus(0, 1, 15'h0001, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("sat_cont0", cont_corr0, CMAX);
    applyStimulus(0, 1, 15'h0001, 0, 0, 1, 1);
    checkOutput("clr_cont0", cont_corr0, 0);

    // Reset while a result is held
    applyStimulus(0, 1, 15'h0010, 0, 0, 0, 0);
    applyStimulus(1, 1, 15'h0010, 1, 15'h0020, 1, 0);
    checkOutput("rst_mid_valid", out_valid, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, randomWord(),
                    $urandom_range(0, 3) != 0, randomWord(),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
